fetch_stage: RTL and testbench

//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC.

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and drives instruction memory over a req/ack handshake.
// It feeds {pc_o, instr_o} to the IF/ID register and handles stalls and branch redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;
    logic [31:0] buffer;
    logic [31:0] buffer_next;
    logic [31:0] redirect;
    logic [31:0] redirect_next;
    logic [31:0] target;
    logic        req;
    logic [31:0] instr;

    // Branch targets are always word aligned.
    assign target = {branch_target_i[31:2], 2'b00};
    assign pc_inc = pc + PC_STEP;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            buffer   <= NOP_INSTR;
            redirect <= 32'h0000_0000;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            buffer   <= buffer_next;
            redirect <= redirect_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        buffer_next   = buffer;
        redirect_next = redirect;
        req           = 1'b0;
        instr         = NOP_INSTR;

        case (state)
            S_REQ: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    if (branch_i) begin
                        // Fetched word is on the wrong path; discard it.
                        pc_next = target;
                    end else if (stall_i) begin
                        instr       = imem_rdata_i;
                        buffer_next = imem_rdata_i;
                        state_next  = S_HOLD;
                    end else begin
                        instr   = imem_rdata_i;
                        pc_next = pc_inc;
                    end
                end else if (branch_i) begin
                    // The request cannot be withdrawn, so wait it out.
                    redirect_next = target;
                    state_next    = S_DRAIN;
                end
            end

            S_DRAIN: begin
                req = 1'b1;
                if (branch_i) begin
                    redirect_next = target;
                end
                if (imem_ack_i) begin
                    pc_next    = branch_i ? target : redirect;
                    state_next = S_REQ;
                end
            end

            S_HOLD: begin
                instr = buffer;
                if (branch_i) begin
                    pc_next    = target;
                    state_next = S_REQ;
                end else if (!stall_i) begin
                    pc_next    = pc_inc;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // Gate with reset so outputs read as idle immediately on async assertion.
    assign imem_req_o  = rst_i & req;
    assign imem_addr_o = pc;
    assign pc_o        = pc;
    assign instr_o     = rst_i ? instr : NOP_INSTR;
    assign flush_o     = rst_i & branch_i;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: variable-latency memory model plus a second
// instance exercising PC wrap from RESET_PC=FFFF_FFFC.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] IDLE = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        flush;

    logic        zero_b;
    logic [31:0] zero_w;
    logic        req_b;
    logic [31:0] addr_b;
    logic        ack_b;
    logic [31:0] rdata_b;
    logic [31:0] pc_b;
    logic [31:0] instr_b;
    logic        flush_b;

    logic [31:0] mem [64];
    int          lat;
    int          wait_cnt;
    int          checks;
    int          errors;

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_o(pc), .instr_o(instr),
        .flush_o(flush)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(zero_b), .branch_i(zero_b),
        .branch_target_i(zero_w), .imem_req_o(req_b), .imem_addr_o(addr_b),
        .imem_ack_i(ack_b), .imem_rdata_i(rdata_b), .pc_o(pc_b), .instr_o(instr_b),
        .flush_o(flush_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after lat cycles of request (lat=1 is zero-wait).
    always_comb begin
        ack   = req && (wait_cnt == lat - 1);
        rdata = ack ? mem[addr[7:2]] : IDLE;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst)      wait_cnt <= 0;
        else if (ack)  wait_cnt <= 0;
        else if (req)  wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        ack_b   = req_b;
        rdata_b = req_b ? mem[addr_b[7:2]] : IDLE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic exp_req, input logic [31:0] exp_pc,
                               input logic [31:0] exp_instr);
        check({tag, ".req"}, {31'd0, req}, {31'd0, exp_req});
        if (exp_req) check({tag, ".addr"}, addr, exp_pc);
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".instr"}, instr, exp_instr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | i;
        zero_b = 1'b0;
        zero_w = 32'h0;
        rst    = 1'b0;
        stall  = 1'b0;
        branch = 1'b0;
        target = 32'h0;
        lat    = 1;

        // Reset state, with branch driven to confirm flush stays low.
        repeat (2) next_cycle();
        branch = 1'b1;
        target = 32'h44;
        #1;
        check("rst.req", {31'd0, req}, 32'd0);
        check("rst.instr", instr, NOP);
        check("rst.pc", pc, 32'h0);
        check("rst.flush", {31'd0, flush}, 32'd0);
        check("rst.wrap_pc", pc_b, 32'hFFFF_FFFC);
        branch = 1'b0;
        rst    = 1'b1;

        // Zero-wait streaming: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            #1;
            check_fetch($sformatf("seq%0d", i), 1'b1, 32'(i * 4), mem[i]);
            if (i == 0) begin
                check("wrap0.pc", pc_b, 32'hFFFF_FFFC);
                check("wrap0.instr", instr_b, mem[63]);
            end
            if (i == 1) begin
                check("wrap1.pc", pc_b, 32'h0);
                check("wrap1.instr", instr_b, mem[0]);
            end
            next_cycle();
        end

        // Fresh reset, then latency-2 fetch of 0x8.
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        lat = 2;
        #1;
        check_fetch("lat2.c0", 1'b1, 32'h8, NOP);
        next_cycle();
        #1;
        check_fetch("lat2.c1", 1'b1, 32'h8, mem[2]);
        next_cycle();

        // Ack with stall held for 3 cycles, then release.
        lat   = 1;
        stall = 1'b1;
        #1;
        check_fetch("stall.ack", 1'b1, 32'hC, mem[3]);
        next_cycle();
        #1;
        check_fetch("stall.h1", 1'b0, 32'hC, mem[3]);
        next_cycle();
        #1;
        check_fetch("stall.h2", 1'b0, 32'hC, mem[3]);
        next_cycle();
        stall = 1'b0;
        lat   = 3;
        #1;
        check_fetch("stall.rel", 1'b0, 32'hC, mem[3]);
        next_cycle();

        // Branch to 0x41 (aligned to 0x40) while 0x10 is pending with latency 3.
        branch = 1'b1;
        target = 32'h41;
        #1;
        check("br.flush", {31'd0, flush}, 32'd1);
        check_fetch("br.c0", 1'b1, 32'h10, NOP);
        next_cycle();
        branch = 1'b0;
        #1;
        check("br.flush_off", {31'd0, flush}, 32'd0);
        check_fetch("br.c1", 1'b1, 32'h10, NOP);
        next_cycle();
        #1;
        check("br.ack", {31'd0, ack}, 32'd1);
        check_fetch("br.c2", 1'b1, 32'h10, NOP);
        next_cycle();
        lat = 1;
        #1;
        check_fetch("br.tgt", 1'b1, 32'h40, mem[16]);

        // Branch and stall together in the hold state: branch wins.
        stall = 1'b1;
        next_cycle();
        branch = 1'b1;
        target = 32'h20;
        #1;
        check("hold_br.flush", {31'd0, flush}, 32'd1);
        check_fetch("hold_br.c0", 1'b0, 32'h40, mem[16]);
        next_cycle();
        stall  = 1'b0;
        branch = 1'b0;
        #1;
        check_fetch("hold_br.tgt", 1'b1, 32'h20, mem[8]);
        next_cycle();

        // Branch coinciding with ack in the request state drops the data.
        branch = 1'b1;
        target = 32'h30;
        #1;
        check_fetch("ackbr.c0", 1'b1, 32'h24, NOP);
        next_cycle();
        branch = 1'b0;
        #1;
        check_fetch("ackbr.tgt", 1'b1, 32'h30, mem[12]);
        next_cycle();

        // Reset asserted mid-request.
        lat = 3;
        #1;
        check_fetch("midrst.pend", 1'b1, 32'h34, NOP);
        next_cycle();
        branch = 1'b1;
        rst    = 1'b0;
        #1;
        check("midrst.req", {31'd0, req}, 32'd0);
        check("midrst.instr", instr, NOP);
        check("midrst.pc", pc, 32'h0);
        check("midrst.flush", {31'd0, flush}, 32'd0);
        branch = 1'b0;
        next_cycle();
        lat = 1;
        rst = 1'b1;
        #1;
        check_fetch("midrst.restart", 1'b1, 32'h0, mem[0]);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
